// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer: frame-synchronous display-mode controller for the VGA
// switch/colour-bar path. It debounces the mode button, holds the requested
// mode as "pending", and commits the mode, mux select and latched switch
// colour only at a frame boundary so that nothing changes mid-frame.
module vga_mode_sequencer #(
  parameter int DEB_CYCLES  = 250000,
  parameter int AUTO_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        v_sync,
  input  logic [3:0]  sw_red,
  input  logic [3:0]  sw_green,
  input  logic [3:0]  sw_blue,
  output logic [1:0]  mode,
  output logic        sel,
  output logic [11:0] rgb_sw,
  output logic        frame_tick
);

  localparam int DEB_W = ($clog2(DEB_CYCLES) > 0) ? $clog2(DEB_CYCLES) : 1;
  localparam int FC_W  = ($clog2(AUTO_FRAMES) > 0) ? $clog2(AUTO_FRAMES) : 1;

  typedef enum logic [1:0] {
    MODE_SW   = 2'd0,
    MODE_BAR  = 2'd1,
    MODE_AUTO = 2'd2
  } mode_e;

  logic             btn_s1_q, btn_s2_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             stable_q, stable_d;
  logic             btn_pulse_q, btn_pulse_d;
  mode_e            pending_q, pending_d;
  logic             vs_q;
  logic             frame_tick_q, frame_tick_d;
  mode_e            mode_q, mode_d;
  logic             sel_q, sel_d;
  logic [11:0]      rgb_q, rgb_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             auto_sel_q, auto_sel_d;

  // Debounce, pending-mode advance and frame-boundary commit logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (otherwise a latch is inferred).
    deb_cnt_d    = '0;
    stable_d     = stable_q;
    pending_d    = pending_q;
    frame_tick_d = vs_q & ~v_sync;
    mode_d       = mode_q;
    sel_d        = sel_q;
    rgb_d        = rgb_q;
    frame_cnt_d  = frame_cnt_q;
    auto_sel_d   = auto_sel_q;

    // A new level is accepted only after it has been seen for DEB_CYCLES
    // consecutive cycles; any return to the stable level restarts the count.
    if (btn_s2_q != stable_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        stable_d = btn_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
    btn_pulse_d = stable_d & ~stable_q;

    // Presses accumulate in pending; they are invisible until the next commit.
    if (btn_pulse_q) begin
      case (pending_q)
        MODE_SW:  pending_d = MODE_BAR;
        MODE_BAR: pending_d = MODE_AUTO;
        default:  pending_d = MODE_SW;
      endcase
    end

    // Commit uses the pending value from before any press landing this cycle.
    if (frame_tick_q) begin
      rgb_d  = {sw_red, sw_green, sw_blue};
      mode_d = pending_q;
      if (pending_q != MODE_AUTO || mode_q != MODE_AUTO) begin
        frame_cnt_d = '0;
        auto_sel_d  = 1'b0;
      end else if (frame_cnt_q == FC_W'(AUTO_FRAMES - 1)) begin
        frame_cnt_d = '0;
        auto_sel_d  = ~auto_sel_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
      case (pending_q)
        MODE_SW:  sel_d = 1'b0;
        MODE_BAR: sel_d = 1'b1;
        default:  sel_d = auto_sel_d;
      endcase
    end
  end

  // State registers; the v_sync history resets high so no tick follows reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      deb_cnt_q    <= '0;
      stable_q     <= 1'b0;
      btn_pulse_q  <= 1'b0;
      pending_q    <= MODE_SW;
      vs_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      mode_q       <= MODE_SW;
      sel_q        <= 1'b0;
      rgb_q        <= '0;
      frame_cnt_q  <= '0;
      auto_sel_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the 2-FF synchroniser a real two-stage chain.
      btn_s1_q     <= btn_mode;
      btn_s2_q     <= btn_s1_q;
      deb_cnt_q    <= deb_cnt_d;
      stable_q     <= stable_d;
      btn_pulse_q  <= btn_pulse_d;
      pending_q    <= pending_d;
      vs_q         <= v_sync;
      frame_tick_q <= frame_tick_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      rgb_q        <= rgb_d;
      frame_cnt_q  <= frame_cnt_d;
      auto_sel_q   <= auto_sel_d;
    end
  end

  assign mode       = mode_q;
  assign sel        = sel_q;
  assign rgb_sw     = rgb_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Testbench for vga_mode_sequencer: directed scenarios with literal
// expectations, then randomized stimulus compared cycle by cycle against a
// behavioural model of the mode/frame rules.
module tb_vga_mode_sequencer;

  localparam int DEB = 4;
  localparam int AF  = 3;

  logic        clk;
  logic        reset;
  logic        btn_mode;
  logic        v_sync;
  logic [3:0]  sw_red, sw_green, sw_blue;
  logic [1:0]  mode;
  logic        sel;
  logic [11:0] rgb_sw;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  vga_mode_sequencer #(.DEB_CYCLES(DEB), .AUTO_FRAMES(AF)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .v_sync(v_sync),
    .sw_red(sw_red), .sw_green(sw_green), .sw_blue(sw_blue),
    .mode(mode), .sel(sel), .rgb_sw(rgb_sw), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Button: a level is accepted once the synchronised input has disagreed
  // with the accepted level for DEB consecutive cycles. Each accepted rising
  // level is one press. In AUTO, sel is (frames since entering AUTO / AF) mod 2.
  int          m_s1, m_s2, m_stable, m_run, m_press, m_pending;
  int          m_vs, m_tick, m_mode, m_sel, m_auto_n;
  logic [11:0] m_rgb;

  always @(posedge clk or negedge reset) begin : model
    int nstable, nrun, npress, npending, ntick;
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_run = 0; m_press = 0;
      m_pending = 0; m_vs = 1; m_tick = 0; m_mode = 0; m_sel = 0;
      m_auto_n = 0; m_rgb = '0;
    end else begin
      nstable = m_stable;
      nrun    = 0;
      if (m_s2 != m_stable) begin
        if (m_run + 1 == DEB) nstable = m_s2;
        else nrun = m_run + 1;
      end
      npress   = (nstable == 1 && m_stable == 0) ? 1 : 0;
      npending = m_press ? (m_pending + 1) % 3 : m_pending;
      ntick    = (m_vs == 1 && v_sync == 1'b0) ? 1 : 0;
      if (m_tick == 1) begin
        m_rgb = {sw_red, sw_green, sw_blue};
        if (m_pending == 2) m_auto_n = (m_mode == 2) ? m_auto_n + 1 : 0;
        if (m_pending == 0)      m_sel = 0;
        else if (m_pending == 1) m_sel = 1;
        else                     m_sel = (m_auto_n / AF) % 2;
        m_mode = m_pending;
      end
      m_s2 = m_s1;
      m_s1 = int'(btn_mode);
      m_stable = nstable; m_run = nrun; m_press = npress;
      m_pending = npending; m_tick = ntick; m_vs = int'(v_sync);
    end
  end

  function automatic logic [15:0] model_out();
    return {2'(m_mode), 1'(m_sel), m_rgb, 1'(m_tick)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One synthetic frame boundary: v_sync low for one cycle; returns one cycle
  // after the commit edge.
  task automatic frame();
    v_sync = 1'b0;
    step(1);
    v_sync = 1'b1;
    step(1);
  endtask

  task automatic press(input int len);
    btn_mode = 1'b1;
    step(len);
    btn_mode = 1'b0;
    step(10);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; btn_mode = 1'b0; v_sync = 1'b1;
    sw_red = 4'h0; sw_green = 4'h0; sw_blue = 4'h0;
    step(5);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      n_checks++;
      if ({mode, sel, rgb_sw, frame_tick} !== 16'h0000) begin
        n_errors++;
        $display("FAIL reset_state cycle %0d: got mode=%0d sel=%0b rgb=%h tick=%0b, expected all zero",
                 i, mode, sel, rgb_sw, frame_tick);
      end
    end
  endtask

  task automatic test_frame_latch();
    {sw_red, sw_green, sw_blue} = 12'hA5C;
    v_sync = 1'b0;
    step(1);
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_errors++; $display("FAIL tick_high: got %0b expected 1", frame_tick);
    end
    v_sync = 1'b1;
    step(1);
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_errors++; $display("FAIL tick_one_cycle: got %0b expected 0", frame_tick);
    end
    n_checks++;
    if (rgb_sw !== 12'hA5C) begin
      n_errors++; $display("FAIL rgb_latch: got %h expected a5c", rgb_sw);
    end
    {sw_red, sw_green, sw_blue} = 12'h123;
    step(6);
    n_checks++;
    if (rgb_sw !== 12'hA5C || frame_tick !== 1'b0) begin
      n_errors++; $display("FAIL rgb_hold: got rgb=%h tick=%0b expected a5c/0", rgb_sw, frame_tick);
    end
    frame();
    n_checks++;
    if (rgb_sw !== 12'h123) begin
      n_errors++; $display("FAIL rgb_next_frame: got %h expected 123", rgb_sw);
    end
  endtask

  task automatic test_debounce();
    press(2);
    frame();
    n_checks++;
    if (mode !== 2'd0) begin
      n_errors++; $display("FAIL bounce_ignored: got mode=%0d expected 0", mode);
    end
    press(10);
    n_checks++;
    if (mode !== 2'd0 || sel !== 1'b0) begin
      n_errors++; $display("FAIL mode_waits_frame: got mode=%0d sel=%0b expected 0/0", mode, sel);
    end
    frame();
    n_checks++;
    if (mode !== 2'd1 || sel !== 1'b1) begin
      n_errors++; $display("FAIL mode_bar: got mode=%0d sel=%0b expected 1/1", mode, sel);
    end
  endtask

  task automatic test_auto();
    logic exp_sel [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    press(6); press(6);           // BAR -> AUTO -> SW
    frame();
    n_checks++;
    if (mode !== 2'd0) begin
      n_errors++; $display("FAIL back_to_sw: got mode=%0d expected 0", mode);
    end
    press(6); press(6);           // SW -> BAR -> AUTO within one frame
    frame();
    n_checks++;
    if (mode !== 2'd2 || sel !== 1'b0) begin
      n_errors++; $display("FAIL enter_auto: got mode=%0d sel=%0b expected 2/0", mode, sel);
    end
    for (int i = 0; i < 6; i++) begin
      step(3);
      frame();
      n_checks++;
      if (sel !== exp_sel[i] || mode !== 2'd2) begin
        n_errors++;
        $display("FAIL auto_sel_frame%0d: got mode=%0d sel=%0b expected 2/%0b", i, mode, sel, exp_sel[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    press(6);                     // AUTO -> SW
    frame();
    n_checks++;
    if (mode !== 2'd0) begin
      n_errors++; $display("FAIL setup_sw: got mode=%0d expected 0", mode);
    end
    // btn_mode rises now; its pulse lands in the same cycle as frame_tick.
    btn_mode = 1'b1;
    step(5);
    v_sync = 1'b0;
    step(1);
    v_sync = 1'b1;
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_errors++; $display("FAIL coincide_tick: got %0b expected 1", frame_tick);
    end
    step(1);
    n_checks++;
    if (mode !== 2'd0) begin
      n_errors++; $display("FAIL coincide_old_pending: got mode=%0d expected 0", mode);
    end
    btn_mode = 1'b0;
    step(10);
    frame();
    n_checks++;
    if (mode !== 2'd1 || sel !== 1'b1) begin
      n_errors++; $display("FAIL coincide_next_frame: got mode=%0d sel=%0b expected 1/1", mode, sel);
    end
  endtask

  task automatic test_reset_mid();
    press(6);                     // BAR -> AUTO
    frame();
    for (int i = 0; i < 3; i++) begin
      step(2);
      frame();
    end
    n_checks++;
    if (mode !== 2'd2 || sel !== 1'b1) begin
      n_errors++; $display("FAIL auto_sel_one: got mode=%0d sel=%0b expected 2/1", mode, sel);
    end
    btn_mode = 1'b1;
    step(4);                      // debounce count now 2
    #2 reset = 1'b0;
    btn_mode = 1'b0;
    #1;
    n_checks++;
    if (mode !== 2'd0 || sel !== 1'b0 || rgb_sw !== 12'h000) begin
      n_errors++; $display("FAIL async_reset: got mode=%0d sel=%0b rgb=%h expected 0/0/000", mode, sel, rgb_sw);
    end
    step(2);
    reset = 1'b1;
    step(2);
    press(3);
    frame();
    n_checks++;
    if (mode !== 2'd0) begin
      n_errors++; $display("FAIL short_press_after_reset: got mode=%0d expected 0", mode);
    end
    press(4);
    frame();
    n_checks++;
    if (mode !== 2'd1) begin
      n_errors++; $display("FAIL full_press_after_reset: got mode=%0d expected 1", mode);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mode, sel, rgb_sw, frame_tick} !== model_out()) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got {mode,sel,rgb,tick}=%h expected %h",
                 i, {mode, sel, rgb_sw, frame_tick}, model_out());
      end
      if (hold == 0) begin
        btn_mode = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 8));
      end else begin
        hold--;
      end
      v_sync = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 3) == 0) {sw_red, sw_green, sw_blue} = 12'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_frame_latch();
    test_debounce();
    test_auto();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_mode_sequencer.md
Name: vga_mode_sequencer

Overview:
- Frame-synchronous controller for the VGA switch/colour-bar display path.
- Debounces a push-button and cycles the display mode SW → BAR → AUTO → SW.
- Drives the 2:1 RGB mux select and a frame-latched copy of the switch colour, so mode and colour changes only take effect at a frame boundary (no mid-frame tearing).
- AUTO mode alternates between switch colour and colour bar every AUTO_FRAMES frames.

Parameters:
- DEB_CYCLES, 250000, stable-level cycles needed to accept a button change (10 ms at 25 MHz).
- AUTO_FRAMES, 60, frames spent on each source in AUTO mode (≥1).

Ports:
- clk  input  1  pixel clock, the single clock domain.
- reset  input  1  asynchronous, active-low reset.
- btn_mode  input  1  raw mode push-button, asynchronous, active-high.
- v_sync  input  1  vertical sync from the VGA decoder, active-low pulse.
- sw_red  input  4  red switch value.
- sw_green  input  4  green switch value.
- sw_blue  input  4  blue switch value.
- mode  output  2  committed mode: 0 = SW, 1 = BAR, 2 = AUTO (3 never driven).
- sel  output  1  mux select: 0 = switch colour, 1 = colour bar.
- rgb_sw  output  12  frame-latched {red, green, blue} switch colour.
- frame_tick  output  1  one-cycle pulse marking the frame boundary.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-low. All state is cleared immediately on assertion.
- Reset values:
  - mode = 0, sel = 0, rgb_sw = 0, frame_tick = 0.
  - pending mode = SW, debounce counter = 0, stable button = 0.
  - v_sync history register = 1, so no spurious tick is produced after reset.
  - auto_sel = 0, frame counter = 0.
- Synchroniser: btn_mode passes through a 2-FF synchroniser before use.
- Debounce:
  - While the synchronised level equals the stable level, the counter holds 0.
  - While they differ, the counter increments each cycle.
  - When the counter reaches DEB_CYCLES-1, stable takes the new level and the counter clears.
  - A rising edge of stable produces btn_pulse, one cycle wide.
  - Any bounce back to the stable level before the threshold clears the counter.
- Pending mode:
  - Each btn_pulse advances pending SW → BAR → AUTO → SW.
  - Several presses inside one frame accumulate.
  - pending is not visible on the outputs until a frame boundary.
- Frame boundary:
  - frame_tick = registered v_sync was 1 and current v_sync is 0 (falling edge).
  - frame_tick is asserted in the cycle after the edge is sampled.
- On each frame_tick cycle:
  - rgb_sw ← {sw_red, sw_green, sw_blue}.
  - mode ← pending.
  - If pending ≠ AUTO, the frame counter and auto_sel clear to 0.
  - If mode was not AUTO and pending = AUTO (entering AUTO), the frame counter and auto_sel clear to 0.
  - If mode = AUTO and pending = AUTO, the frame counter increments. At AUTO_FRAMES-1 it wraps to 0 and auto_sel toggles.
- sel is registered and updates in the same cycle as mode:
  - SW → 0.
  - BAR → 1.
  - AUTO → the next value of auto_sel.
- Latency:
  - sel/mode/rgb_sw change on the clock edge that ends the frame_tick cycle, i.e. 2 cycles after v_sync falls at the synchroniser-free input.
  - Button to pending takes 2 + DEB_CYCLES + 1 cycles.
- Simultaneous btn_pulse and frame_tick: the commit uses the pending value from before the press; the press lands in pending and commits at the next frame.
- Switch inputs: changes between frame_ticks do not affect rgb_sw.
- Reset mid-frame or mid-debounce: all state returns to reset values and the partial debounce count is discarded.
- AUTO_FRAMES = 1: auto_sel toggles on every frame_tick while in AUTO.

Test Plan (DEB_CYCLES=4, AUTO_FRAMES=3, short synthetic frames):
- Reset low for 5 cycles, then released with v_sync held high → mode=0, sel=0, rgb_sw=0x000, no frame_tick.
- Switches 0xA5C, one v_sync falling edge → single 1-cycle frame_tick, rgb_sw=0xA5C. Switches then changed to 0x123 mid-frame → rgb_sw holds 0xA5C until the next tick.
- btn_mode high for 2 cycles only (bounce) → pending unchanged. High for 10 cycles → mode stays 0 until the next frame_tick, then mode=1, sel=1.
- Two clean presses within one frame from SW → at next tick mode=2, sel=0. Following ticks produce sel pattern 0,0,1,1,1,0 (toggles every 3 frames).
- btn_pulse coincident with frame_tick while mode=0 and pending=SW → that tick keeps mode=0; next tick gives mode=1.
- Reset asserted while in AUTO with auto_sel=1 and a partial debounce count of 2 → outputs immediately mode=0, sel=0, rgb_sw=0. The next press still needs the full 4 stable cycles.
